// File: rtl/panel_cmd_sequencer.sv
// Front-panel front end: synchronises and debounces buttons, assembles a 16-bit hex entry,
// and serialises presses into one-cycle command pulses separated by a holdoff gap.
`timescale 1ns/1ps
module panel_cmd_sequencer #(
    parameter int                   NUM_BTN    = 13,
    parameter int                   DEB_CYCLES = 1000,
    parameter int                   GAP        = 4,
    parameter logic [NUM_BTN-1:0]   STOP_MASK  = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [3:0]         key_digit,
    input  logic               key_strobe,
    input  logic               key_clear,
    input  logic               stopped,
    output logic [NUM_BTN-1:0] cmd,
    output logic [15:0]        userInput,
    output logic               inputValid,
    output logic [2:0]         entry_digits,
    output logic               busy,
    output logic               dropped
);
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int IW = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLDOFF} state_t;

    state_t             state, state_nxt;
    logic [NUM_BTN-1:0] sync1, sync2, deb, armed, pending, pending_nxt;
    logic [NUM_BTN-1:0] flip, rise, clr, sel_onehot;
    logic [CW-1:0]      deb_cnt [NUM_BTN];
    logic [1:0]         vld;
    logic [GW-1:0]      gap_cnt;
    logic [IW-1:0]      sel, low_idx;
    logic [15:0]        entry_val_nxt;
    logic [2:0]         entry_cnt_nxt;

    // A press only counts once the button has been seen released after reset.
    always_comb begin
        for (int i = 0; i < NUM_BTN; i++)
            flip[i] = (sync2[i] != deb[i]) && (deb_cnt[i] == CW'(DEB_CYCLES - 1));
        rise = flip & sync2 & armed;
    end

    // NOTE: reset the per-button counter array explicitly; it is state, not storage, and must
    // start from zero like every other register here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            armed <= '0;
            vld   <= '0;
            for (int i = 0; i < NUM_BTN; i++) deb_cnt[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            sync1 <= btn_raw;
            sync2 <= sync1;
            vld   <= {vld[0], 1'b1};
            armed <= armed | ({NUM_BTN{vld[1]}} & ~sync2);
            deb   <= deb ^ flip;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (sync2[i] == deb[i] || flip[i]) deb_cnt[i] <= '0;
                else                               deb_cnt[i] <= deb_cnt[i] + CW'(1);
            end
        end
    end

    // NOTE: every always_comb output gets a default first, so no latch can be inferred.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--)
            if (pending[i]) low_idx = IW'(i);
    end

    assign sel_onehot  = {{(NUM_BTN-1){1'b0}}, 1'b1} << sel;
    assign clr         = (state == ISSUE) ? sel_onehot : '0;
    assign pending_nxt = (pending & ~clr) | rise;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|pending) state_nxt = ISSUE;
            ISSUE:   state_nxt = HOLDOFF;
            HOLDOFF: if (gap_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Clear/consume is applied before a same-cycle digit, so that digit becomes the first one.
    always_comb begin
        logic [15:0] base_val;
        logic [2:0]  base_cnt;
        base_val = (key_clear || (|cmd)) ? 16'h0 : userInput;
        base_cnt = (key_clear || (|cmd)) ? 3'd0  : entry_digits;
        entry_val_nxt = base_val;
        entry_cnt_nxt = base_cnt;
        if (key_strobe) begin
            entry_val_nxt = {base_val[11:0], key_digit};
            entry_cnt_nxt = (base_cnt == 3'd4) ? 3'd4 : base_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            userInput    <= '0;
            entry_digits <= '0;
        end else begin
            userInput    <= entry_val_nxt;
            entry_digits <= entry_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pending    <= '0;
            sel        <= '0;
            gap_cnt    <= '0;
            cmd        <= '0;
            inputValid <= 1'b0;
            dropped    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            pending    <= pending_nxt;
            busy       <= (state_nxt != IDLE) || (|pending_nxt);
            cmd        <= '0;
            inputValid <= 1'b0;
            dropped    <= 1'b0;
            case (state)
                IDLE: sel <= low_idx;
                ISSUE: begin
                    gap_cnt <= GW'(GAP - 1);
                    if (STOP_MASK[sel] && !stopped) begin
                        dropped <= 1'b1;
                    end else begin
                        cmd        <= sel_onehot;
                        inputValid <= (entry_cnt_nxt != 3'd0);
                    end
                end
                HOLDOFF: if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
                default: ;
            endcase
        end
    end
endmodule
